fetch_stage: RTL and testbench

Instruction fetch stage sitting directly upstream of the IF/ID pipeline register. Holds the fetch PC, issues pipelined requests to the instruction memory, and buffers returned instructions in a small queue. Presents one instruction per cycle with its PC and PC+4, honours decode stalls, and discards wrong-path fetches on an execute-stage redirect.

---
 rtl/fetch_stage_pkg.sv | 18 +
 rtl/fetch_stage_if.sv | 15 +
 rtl/fetch_stage_fifo.sv | 63 ++++++
 rtl/fetch_stage.sv | 109 ++++++++++
 tb/tb_fetch_stage.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared widths, NOP encoding and queue entry type for the fetch stage
package fetch_stage_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fq_entry_t;

  // PC arithmetic wraps at 2^PC_W (0xFC + 4 = 0x00).
  function automatic logic [PC_W-1:0] pc_plus4(input logic [PC_W-1:0] pc);
    return pc + PC_W'(4);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory request/response bus
// master (fetch): drives imem_req/imem_addr, receives imem_ack/imem_rdata.
// slave (memory): the reverse; responses return in request order.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/fetch_stage_fifo.sv
// rtl/fetch_stage_fifo.sv - small synchronous FIFO (fetch_fifo) with clear, count and head
// Ports: clk, rst_n (async, active-low), clr_i (sync clear), push_i/din_i,
//        pop_i, count_o (entries held), head_o (oldest entry, undefined when empty).
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [CW-1:0]    count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A push into a full FIFO is only honoured when the head leaves the same cycle.
  assign do_pop  = pop_i & (cnt_q != '0);
  assign do_push = push_i & ((cnt_q != CW'(DEPTH)) | do_pop);

  always_comb begin
    rd_d  = do_pop  ? ptr_inc(rd_q) : rd_q;
    wr_d  = do_push ? ptr_inc(wr_q) : wr_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wr_q] <= din_i;
  end

  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with pipelined imem requests and a small instruction queue
// Ports: clk, rst_n (async, active-low); stallF holds the head entry;
//        pcSrcE/pcTargetE redirect fetch; imem (master) is the memory bus;
//        instrF/pcF/pcPlus4F/validF present the queue head (NOP/0/0/0 when empty).
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stallF,
  input  logic                pcSrcE,
  input  logic [PC_W-1:0]     pcTargetE,
  fetch_stage_if.master       imem,
  output logic [INSTR_W-1:0]  instrF,
  output logic [PC_W-1:0]     pcF,
  output logic [PC_W-1:0]     pcPlus4F,
  output logic                validF
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [PC_W-1:0] fpc_q, fpc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic [CW-1:0]   q_count, a_count;
  logic [PC_W-1:0] a_head;
  fq_entry_t       q_head, q_din;
  logic            pop, issue, ack_v, resp_keep;
  logic [CW:0]     credit_used;

  assign pop = validF & ~stallF & ~pcSrcE;

  // Credits cover both requests still in flight (dropped or not) and queued
  // entries, so a returning response always finds room in the queue.
  assign credit_used = {1'b0, inflight_q} + {1'b0, q_count} - (CW+1)'(pop);
  assign issue       = rst_n & ~pcSrcE & (credit_used < (CW+1)'(DEPTH));

  // An ack with nothing outstanding is a protocol error and is ignored.
  assign ack_v     = imem.imem_ack & (inflight_q != '0);
  assign resp_keep = ack_v & ~pcSrcE & (drop_q == '0);

  always_comb begin
    fpc_d      = fpc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    if (pcSrcE) begin
      // Everything still outstanding belongs to the wrong path.
      fpc_d      = pcTargetE;
      inflight_d = inflight_q - CW'(ack_v);
      drop_d     = inflight_q - CW'(ack_v);
    end else begin
      if (issue) fpc_d = pc_plus4(fpc_q);
      inflight_d = inflight_q + CW'(issue) - CW'(ack_v);
      if (ack_v && drop_q != '0) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_q      <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      fpc_q      <= fpc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  // PCs of non-dropped requests, consumed in response order.
  fetch_fifo #(.WIDTH(PC_W), .DEPTH(DEPTH)) u_addr_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (pcSrcE),
    .push_i  (issue),
    .din_i   (fpc_q),
    .pop_i   (resp_keep),
    .count_o (a_count),
    .head_o  (a_head)
  );

  assign q_din = '{instr: imem.imem_rdata, pc: a_head};

  fetch_fifo #(.WIDTH(INSTR_W + PC_W), .DEPTH(DEPTH)) u_instr_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (pcSrcE),
    .push_i  (resp_keep),
    .din_i   (q_din),
    .pop_i   (pop),
    .count_o (q_count),
    .head_o  (q_head)
  );

  assign imem.imem_req  = issue;
  assign imem.imem_addr = fpc_q;

  assign validF   = (q_count != '0);
  assign instrF   = validF ? q_head.instr : NOP;
  assign pcF      = validF ? q_head.pc : '0;
  assign pcPlus4F = validF ? pc_plus4(q_head.pc) : '0;

  logic unused_ok;
  assign unused_ok = ^a_count;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage with an in-order memory model
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int DEPTH = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               stallF = 1'b0;
  logic               pcSrcE = 1'b0;
  logic [PC_W-1:0]    pcTargetE = '0;
  logic [INSTR_W-1:0] instrF;
  logic [PC_W-1:0]    pcF, pcPlus4F;
  logic               validF;

  fetch_stage_if ifc ();

  fetch_stage #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stallF    (stallF),
    .pcSrcE    (pcSrcE),
    .pcTargetE (pcTargetE),
    .imem      (ifc.master),
    .instrF    (instrF),
    .pcF       (pcF),
    .pcPlus4F  (pcPlus4F),
    .validF    (validF)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PC_W-1:0] addr;
    int              due;
  } req_t;

  req_t            pend[$];
  logic [PC_W-1:0] req_log[$];
  int              cyc, lat, last_due, checks, failures, pops;
  logic [PC_W-1:0] exp_pc, exp_req;
  logic            last_req, last_valid;
  logic [PC_W-1:0] last_pc, last_pc4;
  logic [31:0]     last_instr;

  function automatic logic [31:0] mem_word(input logic [PC_W-1:0] a);
    return {~a, a ^ 8'h5A, 8'h37, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    last_due = 0;
    exp_pc   = '0;
    exp_req  = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   ifc.imem_req, 1'b0);
    chk({tag, "_addr"},  ifc.imem_addr, 0);
    chk({tag, "_valid"}, validF, 1'b0);
    chk({tag, "_instr"}, instrF, NOP);
    chk({tag, "_pc"},    pcF, 0);
    chk({tag, "_pc4"},   pcPlus4F, 0);
  endtask

  // One clock cycle: drive at the falling edge, sample 1 unit later, update the model.
  task automatic step(input logic stall, input logic redir, input logic [PC_W-1:0] tgt);
    logic            ack_now;
    logic [PC_W-1:0] p4;
    req_t            r;
    int              due;
    @(negedge clk);
    stallF    = stall;
    pcSrcE    = redir;
    pcTargetE = tgt;
    ack_now   = (pend.size() > 0) && (pend[0].due <= cyc);
    ifc.imem_ack   = ack_now;
    ifc.imem_rdata = ack_now ? mem_word(pend[0].addr) : 32'hDEAD_BEEF;
    #1;
    last_req = ifc.imem_req; last_valid = validF;
    last_pc = pcF; last_pc4 = pcPlus4F; last_instr = instrF;
    if (validF) begin
      p4 = exp_pc + 8'd4;
      chk("head_pc", pcF, exp_pc);
      chk("head_instr", instrF, mem_word(exp_pc));
      chk("head_pc4", pcPlus4F, p4);
    end else begin
      chk("empty_instr", instrF, NOP);
      chk("empty_pc", pcF, 0);
      chk("empty_pc4", pcPlus4F, 0);
    end
    if (cyc == 1) chk("first_req", ifc.imem_req, 1'b1);
    if (redir) chk("no_req_on_redirect", ifc.imem_req, 1'b0);
    if (ifc.imem_req) begin
      chk("imem_addr", ifc.imem_addr, exp_req);
      chk("credit_limit", pend.size() < DEPTH, 1'b1);
    end
    if (validF && !stall && !redir) begin
      exp_pc = exp_pc + 8'd4;
      pops++;
    end
    if (ack_now) void'(pend.pop_front());
    if (ifc.imem_req) begin
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      r.addr = ifc.imem_addr;
      r.due  = due;
      pend.push_back(r);
      req_log.push_back(ifc.imem_addr);
      last_due = due;
      exp_req  = ifc.imem_addr + 8'd4;
    end
    if (redir) begin
      exp_pc  = tgt;
      exp_req = tgt;
    end
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    int n, pops0;
    logic [PC_W-1:0] frz_pc;
    logic [31:0]     frz_instr;
    checks = 0; failures = 0; pops = 0; cyc = 0; lat = 1;
    ifc.imem_ack = 1'b0; ifc.imem_rdata = '0;
    model_reset();

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk_reset_outputs("reset");

    // 1-cycle memory streaming
    @(posedge clk); #1 rst_n = 1'b1; cyc = 1; lat = 1;
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 1'b0, '0);
      if (cyc - 1 >= 3) chk("stream_valid", last_valid, 1'b1);
    end

    // decode stall for 3 cycles
    step(1'b1, 1'b0, '0);
    frz_pc = last_pc; frz_instr = last_instr;
    chk("stall_valid", last_valid, 1'b1);
    step(1'b1, 1'b0, '0);
    chk("stall_frozen_pc", last_pc, frz_pc);
    step(1'b1, 1'b0, '0);
    chk("stall_frozen_instr", last_instr, frz_instr);
    chk("stall_req_drop", last_req, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0);

    // redirect to 0x40 with two requests in flight, 3-cycle memory
    lat = 3;
    n = 0;
    while (pend.size() != 2 && n < 20) begin step(1'b0, 1'b0, '0); n++; end
    chk("setup_two_inflight", pend.size(), 2);
    step(1'b0, 1'b1, 8'h40);
    n = 0;
    do begin step(1'b0, 1'b0, '0); n++; end while (!last_valid && n < 20);
    chk("redir40_pc", last_pc, 8'h40);
    chk("redir40_pc4", last_pc4, 8'h44);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0);

    // redirect coinciding with an ack
    n = 0;
    while (!(pend.size() > 1 && pend[0].due <= cyc) && n < 20) begin step(1'b0, 1'b0, '0); n++; end
    chk("setup_ack_redirect", pend.size() > 1 && pend[0].due <= cyc, 1'b1);
    step(1'b0, 1'b1, 8'h80);
    chk("ack_redirect_no_req", last_req, 1'b0);
    n = 0;
    do begin step(1'b0, 1'b0, '0); n++; end while (!last_valid && n < 20);
    chk("ack_redirect_pc", last_pc, 8'h80);

    // wrap-around: 0xF8, 0xFC, 0x00
    lat = 1;
    step(1'b0, 1'b1, 8'hF8);
    req_log.delete();
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0);
    chk("wrap_req0", (req_log.size() > 0) ? req_log[0] : 8'hEE, 8'hF8);
    chk("wrap_req1", (req_log.size() > 1) ? req_log[1] : 8'hEE, 8'hFC);
    chk("wrap_req2", (req_log.size() > 2) ? req_log[2] : 8'hEE, 8'h00);

    // randomized stalls, redirects and latencies
    pops0 = pops;
    for (int i = 0; i < 400; i++) begin
      if (i % 25 == 0) lat = $urandom_range(1, 4);
      step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5,
           PC_W'({$urandom_range(0, 63), 2'b00}));
    end
    chk("random_progress", (pops - pops0) > 100, 1'b1);

    // asynchronous reset mid-stream
    lat = 1;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0);
    #2 rst_n = 1'b0;
    ifc.imem_ack = 1'b0; stallF = 1'b0; pcSrcE = 1'b0;
    #1;
    chk_reset_outputs("async_reset");
    model_reset();
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1; cyc = 1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, '0);
      if (cyc - 1 >= 3) chk("restart_valid", last_valid, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
